// File: rtl/rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_arbiter_pkg
// Shared types and helpers for the round-robin arbiter.
//   arb_state_t : arbiter control state (ARB_IDLE, ARB_GRANT)
//   wrap_inc    : index increment that wraps from width-1 back to 0 without a
//                 modulo, so non-power-of-two widths stay cheap and correct.
// -----------------------------------------------------------------------------
package rr_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   function automatic int wrap_inc(input int idx, input int width);
      return (idx == width - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/masked_priority_encoder.sv
// -----------------------------------------------------------------------------
// masked_priority_encoder
// Finds the first set bit of i_vec searching upward from i_pivot and wrapping
// past the top bit back to bit 0.
//   WIDTH    : number of input bits
//   LSB      : numbering of the lowest bit of i_vec / o_onehot
// Ports:
//   i_vec    in  WIDTH          candidate vector
//   i_pivot  in  $clog2(WIDTH)  position (0-based) where the search starts
//   o_valid  out 1              any bit of i_vec set
//   o_idx    out $clog2(WIDTH)  0-based position of the winner
//   o_onehot out WIDTH          one-hot winner (zero when o_valid is low)
// -----------------------------------------------------------------------------
module masked_priority_encoder
   import rr_arbiter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int LSB   = 0
) (
   input  logic [LSB+WIDTH-1:LSB]     i_vec,
   input  logic [$clog2(WIDTH)-1:0]   i_pivot,
   output logic                       o_valid,
   output logic [$clog2(WIDTH)-1:0]   o_idx,
   output logic [LSB+WIDTH-1:LSB]     o_onehot
);

   localparam int IDX_W = $clog2(WIDTH);

   // Bits of an index position, as a constant mask over the vector positions:
   // mask(b) has bit i set when bit b of i is set.
   function automatic logic [WIDTH-1:0] idx_bit_mask(input int b);
      logic [WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (((i >> b) & 1) == 1) m = m | (WIDTH'(1) << i);
      end
      return m;
   endfunction

   logic [WIDTH-1:0] vec;
   logic [WIDTH-1:0] upper_vec;
   logic [WIDTH-1:0] search_vec;
   logic [WIDTH-1:0] lowest;

   assign vec = i_vec;

   // Bits at or above the pivot get first pick; if none is set the search
   // wraps and the lowest set bit of the whole vector wins.
   assign upper_vec  = vec & ~((WIDTH'(1) << i_pivot) - WIDTH'(1));
   assign search_vec = (|upper_vec) ? upper_vec : vec;
   // Isolate the lowest set bit (two's-complement trick).
   assign lowest     = search_vec & (~search_vec + WIDTH'(1));

   assign o_valid  = |vec;
   assign o_onehot = lowest;

   genvar gi;
   generate
      for (gi = 0; gi < IDX_W; gi++) begin : g_idx_bit
         assign o_idx[gi] = |(lowest & idx_bit_mask(gi));
      end
   endgenerate

endmodule

// File: rtl/round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// round_robin_arbiter
// Round-robin arbiter sharing one resource among WIDTH requesters. The grant is
// registered and held until the owner drops its request; the next owner is the
// first requester after the previous owner, handed off on the same edge.
// Optional feature macro: RR_ARB_TIMEOUT_EN (forced handoff after MAX_HOLD
// cycles, signalled by o_timeout).
// Ports:
//   i_clk      in  1              clock, rising edge
//   i_rst_n    in  1              asynchronous active-low reset
//   i_req      in  WIDTH          level request per requester
//   o_gnt      out WIDTH          registered one-hot grant
//   o_gnt_idx  out $clog2(WIDTH)  owner index, valid while o_busy is high
//   o_busy     out 1              a grant is active
//   o_timeout  out 1              one-cycle pulse on forced handoff (macro only)
// -----------------------------------------------------------------------------
module round_robin_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [WIDTH-1:0]          i_req,
   output logic [WIDTH-1:0]          o_gnt,
   output logic [$clog2(WIDTH)-1:0]  o_gnt_idx,
   output logic                      o_busy
`ifdef RR_ARB_TIMEOUT_EN
   ,
   output logic                      o_timeout
`endif
);

   localparam int IDX_W = $clog2(WIDTH);

   arb_state_t        state_q, state_d;
   logic [WIDTH-1:0]  gnt_q, gnt_d;
   logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0]  last_idx_q, last_idx_d;

   logic [IDX_W-1:0]  pivot;
   logic [WIDTH-1:0]  cand_vec;
   logic              enc_valid;
   logic [IDX_W-1:0]  enc_idx;
   logic [WIDTH-1:0]  enc_onehot;
   logic              owner_req;
   logic              take;

   assign owner_req = |(i_req & gnt_q);
   assign pivot     = IDX_W'(wrap_inc(int'(last_idx_q), WIDTH));

`ifdef RR_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD + 1);

   logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic              timeout_q, timeout_d;
   logic              hold_expired;

   assign hold_expired = (state_q == ARB_GRANT) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
   // On expiry the owner is masked out so only other requesters can win.
   assign cand_vec     = (hold_expired && owner_req) ? (i_req & ~gnt_q) : i_req;
   assign o_timeout    = timeout_q;
`else
   // MAX_HOLD only matters when the hold timeout is compiled in.
   logic [31:0] unused_max_hold;
   assign unused_max_hold = 32'(MAX_HOLD);
   assign cand_vec        = i_req;
`endif

   masked_priority_encoder #(
      .WIDTH (WIDTH),
      .LSB   (0)
   ) u_enc (
      .i_vec    (cand_vec),
      .i_pivot  (pivot),
      .o_valid  (enc_valid),
      .o_idx    (enc_idx),
      .o_onehot (enc_onehot)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      gnt_idx_d  = gnt_idx_q;
      last_idx_d = last_idx_q;
      take       = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;
`endif
      unique case (state_q)
         ARB_IDLE: begin
            take = enc_valid;
         end
         ARB_GRANT: begin
            if (!owner_req) begin
               // Owner released: hand off immediately or fall back to idle.
               take = enc_valid;
               if (!enc_valid) begin
                  state_d = ARB_IDLE;
                  gnt_d   = '0;
               end
            end
`ifdef RR_ARB_TIMEOUT_EN
            else if (hold_expired) begin
               take      = enc_valid;
               timeout_d = enc_valid;
               // Nobody else waiting: owner keeps the grant, window restarts.
               if (!enc_valid) hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
`endif
         end
         default: ;
      endcase
      if (take) begin
         state_d    = ARB_GRANT;
         gnt_d      = enc_onehot;
         gnt_idx_d  = enc_idx;
         last_idx_d = enc_idx;
`ifdef RR_ARB_TIMEOUT_EN
         hold_cnt_d = '0;
`endif
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ARB_IDLE;
         gnt_q      <= '0;
         gnt_idx_q  <= '0;
         // Start "after" the top index so the first arbitration favours 0.
         last_idx_q <= IDX_W'(WIDTH - 1);
`ifdef RR_ARB_TIMEOUT_EN
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gnt_idx_q  <= gnt_idx_d;
         last_idx_q <= last_idx_d;
`ifdef RR_ARB_TIMEOUT_EN
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign o_gnt     = gnt_q;
   assign o_gnt_idx = gnt_idx_q;
   assign o_busy    = (state_q == ARB_GRANT);

endmodule
